// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product accumulator core and its stream loader.
//   dot_state_e : loader FSM states (IDLE / SHIFT / SETTLE)
//   NIB_W       : nibble width streamed into the core per cycle
//   RES_W       : width of the core's running-maximum result
package dot_pkg;

  localparam int NIB_W = 4;
  localparam int RES_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2
  } dot_state_e;

endpackage

// File: rtl/dot_stream_loader_if.sv
// Host-side word handshake into dot_stream_loader.
//   s_valid/s_data/s_sel : word offered by the host (master drives)
//   s_ready              : loader can take a word (slave drives)
interface dot_stream_loader_if #(
  parameter int NIBBLES = 4
);

  logic                   s_valid;
  logic                   s_ready;
  logic [4*NIBBLES-1:0]   s_data;
  logic                   s_sel;

  modport master (output s_valid, output s_data, output s_sel, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_sel, output s_ready);

endinterface

// File: rtl/dot_stream_loader.sv
// Streams a host word into the accumulator core one nibble per cycle (LSB
// nibble first), waits SETTLE_CYCLES for the core to update, then captures
// the core's running maximum and pulses res_valid for one cycle.
// Ports:
//   clk, rst_n              : clock; rst_n is an active-HIGH async reset
//   s_valid/s_ready/s_data/s_sel : host word handshake (accept in IDLE only)
//   nib_out/nib_sel/nib_en  : nibble stream to core ui_in[3:0] / uio_in[7]
//   busy                    : high whenever not IDLE
//   res_in                  : running maximum from the core
//   res_data/res_valid      : captured result and its one-cycle strobe
module dot_stream_loader
  import dot_pkg::*;
#(
  parameter int NIBBLES       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NIB_W*NIBBLES-1:0] s_data,
  input  logic                    s_sel,
  output logic [NIB_W-1:0]        nib_out,
  output logic                    nib_sel,
  output logic                    nib_en,
  output logic                    busy,
  input  logic [RES_W-1:0]        res_in,
  output logic [RES_W-1:0]        res_data,
  output logic                    res_valid
);

  localparam int DW = NIB_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] NIB_LAST    = CW'(NIBBLES - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  dot_state_e        state_q, state_d;
  logic [DW-1:0]     sh_q, sh_d;
  logic              sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        wait_q, wait_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          sh_d    = s_data;
          sel_d   = s_sel;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d = sh_q >> NIB_W;
        if (cnt_q == NIB_LAST) begin
          wait_d  = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        // res_in is only looked at on the last settle edge
        if (wait_q == SETTLE_LAST) begin
          res_data_d  = res_in;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      wait_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Outputs are pure decodes of flops; nib_sel keeps the last latched target.
  assign s_ready   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign nib_en    = (state_q == SHIFT);
  assign nib_out   = (state_q == SHIFT) ? sh_q[NIB_W-1:0] : '0;
  assign nib_sel   = sel_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_dot_stream_loader.sv
module tb_dot_stream_loader;

  typedef struct { int cyc; logic [4:0] v; } nib_t;
  typedef struct { int cyc; logic [9:0] v; } res_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  dot_stream_loader_if #(.NIBBLES(4)) sif ();
  dot_stream_loader_if #(.NIBBLES(4)) sif2 ();

  logic [3:0] nib_out, nib_out2;
  logic       nib_sel, nib_sel2, nib_en, nib_en2, busy, busy2;
  logic [9:0] res_in, res_in2, res_data, res_data2;
  logic       res_valid, res_valid2;

  nib_t nq[$], nq2[$];
  res_t rq[$], rq2[$];

  dot_stream_loader #(.NIBBLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sif.s_valid), .s_ready(sif.s_ready), .s_data(sif.s_data), .s_sel(sif.s_sel),
    .nib_out(nib_out), .nib_sel(nib_sel), .nib_en(nib_en), .busy(busy),
    .res_in(res_in), .res_data(res_data), .res_valid(res_valid)
  );

  dot_stream_loader #(.NIBBLES(4), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sif2.s_valid), .s_ready(sif2.s_ready), .s_data(sif2.s_data), .s_sel(sif2.s_sel),
    .nib_out(nib_out2), .nib_sel(nib_sel2), .nib_en(nib_en2), .busy(busy2),
    .res_in(res_in2), .res_data(res_data2), .res_valid(res_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop expected nibbles/results whenever the DUT presents one.
  always @(negedge clk) begin
    nib_t n;
    res_t r;
    if (nib_en) begin
      if (nq.size() == 0) chk("nib_unexpected", {27'd0, nib_sel, nib_out}, 32'hFFFF_FFFF);
      else begin
        n = nq.pop_front();
        chk("nib_cyc", cyc, n.cyc);
        chk("nib_val", {27'd0, nib_sel, nib_out}, {27'd0, n.v});
      end
    end
    if (res_valid) begin
      if (rq.size() == 0) chk("res_unexpected", {22'd0, res_data}, 32'hFFFF_FFFF);
      else begin
        r = rq.pop_front();
        chk("res_cyc", cyc, r.cyc);
        chk("res_val", {22'd0, res_data}, {22'd0, r.v});
      end
    end
  end

  always @(negedge clk) begin
    nib_t n;
    res_t r;
    if (nib_en2) begin
      if (nq2.size() == 0) chk("nib2_unexpected", {27'd0, nib_sel2, nib_out2}, 32'hFFFF_FFFF);
      else begin
        n = nq2.pop_front();
        chk("nib2_cyc", cyc, n.cyc);
        chk("nib2_val", {27'd0, nib_sel2, nib_out2}, {27'd0, n.v});
      end
    end
    if (res_valid2) begin
      if (rq2.size() == 0) chk("res2_unexpected", {22'd0, res_data2}, 32'hFFFF_FFFF);
      else begin
        r = rq2.pop_front();
        chk("res2_cyc", cyc, r.cyc);
        chk("res2_val", {22'd0, res_data2}, {22'd0, r.v});
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Call at a negedge; returns just after the accepting edge with a = cyc.
  task automatic accept(input logic [15:0] d, input logic s, input bit hold, output int a);
    sif.s_valid = 1'b1; sif.s_data = d; sif.s_sel = s;
    chk("s_ready_pre", {31'd0, sif.s_ready}, 32'd1);
    @(posedge clk); #1;
    a = cyc;
    if (!hold) sif.s_valid = 1'b0;
  endtask

  task automatic push4(input int a, input logic [3:0] n0, n1, n2, n3, input logic s);
    nq.push_back('{a,     {s, n0}});
    nq.push_back('{a + 1, {s, n1}});
    nq.push_back('{a + 2, {s, n2}});
    nq.push_back('{a + 3, {s, n3}});
  endtask

  initial begin
    int a, b;
    total = 0; bad = 0; cyc = 0;
    sif.s_valid = 0; sif.s_data = 0; sif.s_sel = 0;
    sif2.s_valid = 0; sif2.s_data = 0; sif2.s_sel = 0;
    res_in = 10'h011; res_in2 = 10'h022;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #2;
    chk("rst_s_ready", {31'd0, sif.s_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_nib_en", {31'd0, nib_en}, 32'd0);
    chk("rst_nib_out", {28'd0, nib_out}, 32'd0);
    chk("rst_nib_sel", {31'd0, nib_sel}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {22'd0, res_data}, 32'd0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);

    // Basic word: 0x4321 to weights
    accept(16'h4321, 1'b1, 0, a);
    push4(a, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    wait_cyc(a + 1);
    chk("shift_busy", {31'd0, busy}, 32'd1);
    chk("shift_s_ready", {31'd0, sif.s_ready}, 32'd0);
    wait_cyc(a + 4);
    chk("settle_nib_en", {31'd0, nib_en}, 32'd0);
    chk("settle_nib_out", {28'd0, nib_out}, 32'd0);
    chk("settle_nib_sel", {31'd0, nib_sel}, 32'd1);
    wait_cyc(a + 5); res_in = 10'h3FF;
    rq.push_back('{a + 6, 10'h3FF});
    wait_cyc(a + 6); res_in = 10'h011;
    chk("idle_s_ready", {31'd0, sif.s_ready}, 32'd1);
    wait_cyc(a + 7);
    chk("res_hold", {22'd0, res_data}, 32'h3FF);
    chk("res_valid_low", {31'd0, res_valid}, 32'd0);

    // Back-to-back with s_valid held high
    accept(16'h000F, 1'b0, 1, a);
    sif.s_data = 16'hF000; sif.s_sel = 1'b1;
    push4(a, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    push4(a + 7, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
    wait_cyc(a + 5); res_in = 10'h0AA;
    rq.push_back('{a + 6, 10'h0AA});
    wait_cyc(a + 6); res_in = 10'h011;
    wait_cyc(a + 7);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    sif.s_valid = 1'b0; sif.s_data = 16'h5555;
    wait_cyc(a + 12); res_in = 10'h155;
    rq.push_back('{a + 13, 10'h155});
    wait_cyc(a + 13); res_in = 10'h011;
    wait_cyc(a + 15);

    // Input noise during SHIFT must not disturb the stream
    accept(16'h8C3A, 1'b0, 0, a);
    push4(a, 4'hA, 4'h3, 4'hC, 4'h8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sif.s_valid = 1'($urandom_range(0, 1));
      sif.s_data  = 16'($urandom);
      sif.s_sel   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
    wait_cyc(a + 5); res_in = 10'h2A5;
    rq.push_back('{a + 6, 10'h2A5});
    wait_cyc(a + 6); res_in = 10'h011;
    wait_cyc(a + 8);

    // Reset in the second SHIFT cycle abandons the word
    accept(16'hABCD, 1'b1, 0, a);
    nq.push_back('{a, 5'h1D});
    nq.push_back('{a + 1, 5'h1C});
    wait_cyc(a + 1);
    #2 rst_n = 1'b1;
    #1;
    chk("mid_rst_nib_en", {31'd0, nib_en}, 32'd0);
    chk("mid_rst_nib_out", {28'd0, nib_out}, 32'd0);
    chk("mid_rst_nib_sel", {31'd0, nib_sel}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, sif.s_ready}, 32'd1);
    chk("mid_rst_res_data", {22'd0, res_data}, 32'd0);
    @(negedge clk); rst_n = 1'b0;
    accept(16'h0765, 1'b0, 0, b);
    push4(b, 4'h5, 4'h6, 4'h7, 4'h0, 1'b0);
    wait_cyc(b + 5); res_in = 10'h100;
    rq.push_back('{b + 6, 10'h100});
    wait_cyc(b + 6); res_in = 10'h011;
    wait_cyc(b + 8);

    // SETTLE_CYCLES = 1 instance
    sif2.s_valid = 1'b1; sif2.s_data = 16'h0009; sif2.s_sel = 1'b1;
    chk("s2_ready_pre", {31'd0, sif2.s_ready}, 32'd1);
    @(posedge clk); #1;
    a = cyc;
    sif2.s_valid = 1'b0;
    nq2.push_back('{a,     5'h19});
    nq2.push_back('{a + 1, 5'h10});
    nq2.push_back('{a + 2, 5'h10});
    nq2.push_back('{a + 3, 5'h10});
    wait_cyc(a + 4); res_in2 = 10'h155;
    rq2.push_back('{a + 5, 10'h155});
    wait_cyc(a + 5); res_in2 = 10'h022;
    chk("s2_idle_ready", {31'd0, sif2.s_ready}, 32'd1);
    wait_cyc(a + 7);
    chk("s2_res_hold", {22'd0, res_data2}, 32'h155);

    chk("nq_drained", nq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    chk("nq2_drained", nq2.size(), 32'd0);
    chk("rq2_drained", rq2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
